// File: rtl/dnoc_l2_wr_arb_if.sv
// rtl/dnoc_l2_wr_arb_if.sv - write-master and L2 write-port handshake bundle
//
// Carries the per-master write req/gnt/addr/data/resp signals and the shared
// L2 dmem write port.
//   slave  : the arbiter (takes master requests, drives the L2 port)
//   master : the write engines plus the L2 bank model (drive requests and L2 gnt/resp)
interface dnoc_l2_wr_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 256
);
  logic [NUM_REQ-1:0]        m_wr_req;
  logic [NUM_REQ-1:0]        m_wr_gnt;
  logic [NUM_REQ*ADDR_W-1:0] m_wr_addr;
  logic [NUM_REQ*DATA_W-1:0] m_wr_data;
  logic [NUM_REQ-1:0]        m_wr_resp;
  logic                      L2_dmem_wr_req;
  logic                      L2_dmem_wr_gnt;
  logic [ADDR_W-1:0]         L2_dmem_wr_addr;
  logic [DATA_W-1:0]         L2_dmem_wr_data;
  logic                      L2_dmem_wr_resp;

  modport slave (
    input  m_wr_req, m_wr_addr, m_wr_data, L2_dmem_wr_gnt, L2_dmem_wr_resp,
    output m_wr_gnt, m_wr_resp, L2_dmem_wr_req, L2_dmem_wr_addr, L2_dmem_wr_data
  );

  modport master (
    output m_wr_req, m_wr_addr, m_wr_data, L2_dmem_wr_gnt, L2_dmem_wr_resp,
    input  m_wr_gnt, m_wr_resp, L2_dmem_wr_req, L2_dmem_wr_addr, L2_dmem_wr_data
  );
endinterface

// File: rtl/dnoc_l2_wr_arb.sv
// rtl/dnoc_l2_wr_arb.sv - round-robin arbiter sharing the L2 dmem write port
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   bus (slave)      per-master write req/gnt/addr/data/resp and the shared L2 write port
//   outstanding_cnt  number of issued writes still waiting for an L2 response
//   arb_idle         no master requesting and nothing in flight
//   resp_err         sticky: an L2 response arrived with nothing in flight
module dnoc_l2_wr_arb #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 13,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  dnoc_l2_wr_arb_if.slave                      bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                                 arb_idle,
  output logic                                 resp_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_fifo_q [MAX_OUTSTANDING];
  logic [ID_W-1:0]  id_fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_err_q, resp_err_d;

  logic [ID_W-1:0]  win;
  logic             can_issue;
  logic             push;
  logic             pop;
  logic [NUM_REQ-1:0] one_hot_base;

  assign one_hot_base = NUM_REQ'(1);

  // Round-robin pick: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && bus.m_wr_req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Issue is gated only by the registered count, so a response arriving in
  // the same cycle never frees a slot combinationally.
  assign can_issue           = (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign bus.L2_dmem_wr_req  = (|bus.m_wr_req) & can_issue;
  assign bus.L2_dmem_wr_addr = bus.m_wr_addr[win*ADDR_W +: ADDR_W];
  assign bus.L2_dmem_wr_data = bus.m_wr_data[win*DATA_W +: DATA_W];

  assign push = bus.L2_dmem_wr_req & bus.L2_dmem_wr_gnt;
  assign pop  = bus.L2_dmem_wr_resp & (cnt_q != '0);

  assign bus.m_wr_gnt  = push ? (one_hot_base << win) : '0;
  assign bus.m_wr_resp = pop ? (one_hot_base << id_fifo_q[rd_ptr_q]) : '0;

  assign outstanding_cnt = cnt_q;
  assign resp_err        = resp_err_q;
  assign arb_idle        = ~(|bus.m_wr_req) & (cnt_q == '0);

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    id_fifo_d  = id_fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    resp_err_d = resp_err_q;

    if (push) begin
      id_fifo_d[wr_ptr_q] = win;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      if (int'(win) == NUM_REQ - 1) rr_ptr_d = '0;
      else                          rr_ptr_d = win + ID_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A response with nothing in flight has no owner; drop it and flag.
    if (bus.L2_dmem_wr_resp && (cnt_q == '0)) begin
      resp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_fifo_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      resp_err_q <= resp_err_d;
      id_fifo_q  <= id_fifo_d;
    end
  end

endmodule

// File: tb/tb_dnoc_l2_wr_arb.sv
// tb/tb_dnoc_l2_wr_arb.sv - self-checking bench for dnoc_l2_wr_arb
module tb_dnoc_l2_wr_arb;
  localparam int N    = 2;
  localparam int AW   = 13;
  localparam int DW   = 256;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dnoc_l2_wr_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [2:0] outstanding_cnt;
  logic       arb_idle;
  logic       resp_err;

  dnoc_l2_wr_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt),
    .arb_idle        (arb_idle),
    .resp_err        (resp_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight IDs in issue order, rotating priority pointer, sticky error.
  int mq[$];
  int m_rr = 0;
  bit m_err = 0;
  int cyc = 0;

  // Values captured during the most recent step
  bit         hs;
  int         hs_win;
  int         step_cyc;
  logic [N-1:0] d_gnt;
  logic [N-1:0] d_resp;
  logic       d_l2req;
  int         d_cnt;

  task automatic new_beat(input int m);
    bus.m_wr_addr[m*AW +: AW] = AW'($urandom);
    for (int k = 0; k < DW / 32; k++) bus.m_wr_data[m*DW + k*32 +: 32] = $urandom;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr  = 0;
    m_err = 0;
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+4, then the model advances.
  task automatic step();
    int win;
    bit any, can, exp_req;
    logic [N-1:0] exp_gnt, exp_resp, one;
    one = 1;
    #3;
    any = |bus.m_wr_req;
    can = mq.size() < MAXO;
    win = 0;
    for (int i = N - 1; i >= 0; i--) if (bus.m_wr_req[(m_rr + i) % N]) win = (m_rr + i) % N;
    exp_req  = any && can;
    exp_gnt  = (exp_req && bus.L2_dmem_wr_gnt) ? (one << win) : '0;
    exp_resp = (bus.L2_dmem_wr_resp && mq.size() > 0) ? (one << mq[0]) : '0;

    d_gnt = bus.m_wr_gnt; d_resp = bus.m_wr_resp; d_l2req = bus.L2_dmem_wr_req;
    d_cnt = int'(outstanding_cnt);

    checks++; if (d_cnt !== mq.size()) begin errors++;
      $display("FAIL cnt cyc=%0d got %0d exp %0d", cyc, d_cnt, mq.size()); end
    checks++; if (d_l2req !== exp_req) begin errors++;
      $display("FAIL l2_req cyc=%0d got %0b exp %0b", cyc, d_l2req, exp_req); end
    checks++; if (d_gnt !== exp_gnt) begin errors++;
      $display("FAIL gnt cyc=%0d got %b exp %b", cyc, d_gnt, exp_gnt); end
    checks++; if (d_resp !== exp_resp) begin errors++;
      $display("FAIL resp cyc=%0d got %b exp %b", cyc, d_resp, exp_resp); end
    checks++; if (arb_idle !== (!any && mq.size() == 0)) begin errors++;
      $display("FAIL idle cyc=%0d got %0b", cyc, arb_idle); end
    checks++; if (resp_err !== m_err) begin errors++;
      $display("FAIL resp_err cyc=%0d got %0b exp %0b", cyc, resp_err, m_err); end
    if (exp_req) begin
      checks++; if (bus.L2_dmem_wr_addr !== bus.m_wr_addr[win*AW +: AW]) begin errors++;
        $display("FAIL addr cyc=%0d got %h exp %h", cyc, bus.L2_dmem_wr_addr, bus.m_wr_addr[win*AW +: AW]); end
      checks++; if (bus.L2_dmem_wr_data !== bus.m_wr_data[win*DW +: DW]) begin errors++;
        $display("FAIL data cyc=%0d master %0d", cyc, win); end
    end

    hs = exp_req && bus.L2_dmem_wr_gnt;
    hs_win = win;
    step_cyc = cyc;
    if (bus.L2_dmem_wr_resp) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_err = 1;
    end
    if (hs) begin
      mq.push_back(win);
      m_rr = (win + 1) % N;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    bus.m_wr_req = '0; bus.L2_dmem_wr_gnt = 0;
    for (int i = 0; i < 2 * MAXO && mq.size() > 0; i++) begin
      bus.L2_dmem_wr_resp = 1; step();
    end
    bus.L2_dmem_wr_resp = 0;
    checks++; if (mq.size() != 0) begin errors++;
      $display("FAIL drain left %0d in flight", mq.size()); end
  endtask

  task automatic test_reset();
    bus.m_wr_req = '0; bus.L2_dmem_wr_gnt = 0; bus.L2_dmem_wr_resp = 0;
    for (int m = 0; m < N; m++) new_beat(m);
    #12;
    checks++; if (outstanding_cnt !== 3'd0 || resp_err !== 1'b0 || arb_idle !== 1'b1) begin errors++;
      $display("FAIL reset_state cnt %0d err %0b idle %0b", outstanding_cnt, resp_err, arb_idle); end
    checks++; if (bus.m_wr_gnt !== '0 || bus.m_wr_resp !== '0 || bus.L2_dmem_wr_req !== 1'b0) begin errors++;
      $display("FAIL reset_outputs gnt %b resp %b req %0b", bus.m_wr_gnt, bus.m_wr_resp, bus.L2_dmem_wr_req); end
    #5 rst_n = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_single();
    int due[$];
    int issued = 0, gcnt = 0, rcnt = 0, peak = 0;
    new_beat(0);
    for (int c = 0; c < 30; c++) begin
      bus.m_wr_req = (issued < 6) ? 2'b01 : 2'b00;
      bus.L2_dmem_wr_gnt = 1;
      bus.L2_dmem_wr_resp = (due.size() > 0 && due[0] == cyc);
      if (bus.L2_dmem_wr_resp) void'(due.pop_front());
      step();
      if (d_gnt[0]) gcnt++;
      if (d_resp[0]) rcnt++;
      if (d_cnt > peak) peak = d_cnt;
      if (hs) begin issued++; due.push_back(step_cyc + 2); new_beat(0); end
      if (issued == 6 && due.size() == 0 && mq.size() == 0) break;
    end
    bus.m_wr_req = '0; bus.L2_dmem_wr_resp = 0;
    #3;
    checks++; if (gcnt !== 6) begin errors++; $display("FAIL single_gnt got %0d exp 6", gcnt); end
    checks++; if (rcnt !== 6) begin errors++; $display("FAIL single_resp got %0d exp 6", rcnt); end
    checks++; if (peak !== 2) begin errors++; $display("FAIL single_peak got %0d exp 2", peak); end
    checks++; if (outstanding_cnt !== 3'd0 || arb_idle !== 1'b1) begin errors++;
      $display("FAIL single_end cnt %0d idle %0b", outstanding_cnt, arb_idle); end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic test_alternate();
    int due[$];
    int gq[$];
    int prev = -1, ng = 0;
    for (int m = 0; m < N; m++) new_beat(m);
    for (int c = 0; c < 40; c++) begin
      bus.m_wr_req = (ng < 10) ? 2'b11 : 2'b00;
      bus.L2_dmem_wr_gnt = 1;
      bus.L2_dmem_wr_resp = (due.size() > 0 && due[0] == cyc);
      if (bus.L2_dmem_wr_resp) void'(due.pop_front());
      step();
      if (d_gnt != '0) begin
        int w;
        w = d_gnt[1] ? 1 : 0;
        checks++; if (prev >= 0 && w == prev) begin errors++;
          $display("FAIL alternate grant %0d repeated master %0d", ng, w); end
        prev = w; gq.push_back(w); ng++;
      end
      if (d_resp != '0) begin
        int r, e;
        r = d_resp[1] ? 1 : 0;
        e = (gq.size() > 0) ? gq.pop_front() : -1;
        checks++; if (r != e) begin errors++;
          $display("FAIL resp_order got master %0d exp %0d", r, e); end
      end
      if (hs) begin due.push_back(step_cyc + 2); new_beat(hs_win); end
      if (ng >= 10 && due.size() == 0 && mq.size() == 0) break;
    end
    checks++; if (ng != 10 || gq.size() != 0) begin errors++;
      $display("FAIL alternate_count grants %0d unanswered %0d", ng, gq.size()); end
    bus.L2_dmem_wr_resp = 0;
  endtask

  task automatic test_full();
    int ng = 0;
    bus.m_wr_req = 2'b11; bus.L2_dmem_wr_gnt = 1; bus.L2_dmem_wr_resp = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (d_gnt != '0) ng++;
      if (hs) new_beat(hs_win);
    end
    checks++; if (ng != MAXO) begin errors++; $display("FAIL full_grants got %0d exp %0d", ng, MAXO); end
    checks++; if (d_l2req !== 1'b0) begin errors++; $display("FAIL full_req got %0b exp 0", d_l2req); end
    bus.L2_dmem_wr_resp = 1;
    step();
    checks++; if (d_gnt !== '0) begin errors++; $display("FAIL full_same_cycle gnt %b exp 00", d_gnt); end
    if (hs) new_beat(hs_win);
    bus.L2_dmem_wr_resp = 0;
    step();
    checks++; if (d_gnt == '0) begin errors++; $display("FAIL full_next_gnt got %b exp nonzero", d_gnt); end
    drain();
  endtask

  task automatic test_stall();
    int sw;
    logic [N-1:0] one;
    one = 1;
    sw = m_rr;
    bus.m_wr_req = 2'b11; bus.L2_dmem_wr_gnt = 0; bus.L2_dmem_wr_resp = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (d_gnt !== '0 || d_l2req !== 1'b1) begin errors++;
        $display("FAIL stall gnt %b req %0b", d_gnt, d_l2req); end
    end
    bus.L2_dmem_wr_gnt = 1;
    step();
    checks++; if (d_gnt !== (one << sw)) begin errors++;
      $display("FAIL stall_winner got %b exp %b", d_gnt, one << sw); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++)
        if (!bus.m_wr_req[m] && ($urandom % 2 == 0)) begin bus.m_wr_req[m] = 1; new_beat(m); end
      bus.L2_dmem_wr_gnt  = ($urandom % 4 != 0);
      bus.L2_dmem_wr_resp = (mq.size() > 0) && ($urandom % 3 != 0);
      step();
      if (hs) begin bus.m_wr_req[hs_win] = $urandom % 2; new_beat(hs_win); end
    end
    drain();
  endtask

  task automatic test_resp_err();
    bus.m_wr_req = '0; bus.L2_dmem_wr_gnt = 0;
    bus.L2_dmem_wr_resp = 1;
    step();
    bus.L2_dmem_wr_resp = 0;
    for (int c = 0; c < 4; c++) step();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL resp_err_sticky got %0b exp 1", resp_err); end
  endtask

  task automatic test_reset_mid();
    bus.m_wr_req = 2'b01; bus.L2_dmem_wr_gnt = 1; bus.L2_dmem_wr_resp = 0;
    for (int c = 0; c < 3; c++) begin step(); if (hs) new_beat(0); end
    checks++; if (outstanding_cnt !== 3'd3) begin errors++;
      $display("FAIL pre_reset_cnt got %0d exp 3", outstanding_cnt); end
    bus.m_wr_req = '0; bus.L2_dmem_wr_gnt = 0;
    #2 rst_n = 0;
    #2;
    checks++; if (outstanding_cnt !== 3'd0 || resp_err !== 1'b0 || arb_idle !== 1'b1) begin errors++;
      $display("FAIL mid_reset_state cnt %0d err %0b idle %0b", outstanding_cnt, resp_err, arb_idle); end
    checks++; if (bus.m_wr_gnt !== '0 || bus.m_wr_resp !== '0 || bus.L2_dmem_wr_req !== 1'b0) begin errors++;
      $display("FAIL mid_reset_outputs gnt %b resp %b req %0b", bus.m_wr_gnt, bus.m_wr_resp, bus.L2_dmem_wr_req); end
    model_reset();
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1; cyc += 2;
    bus.L2_dmem_wr_resp = 1;
    step();
    bus.L2_dmem_wr_resp = 0;
    step();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL late_resp_err got %0b exp 1", resp_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_stall();
    test_random();
    test_resp_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
